// File: rtl/gpio_bank_ctrl.sv
// GPIO bank controller: direction/output registers, synchronised input readback, masked edge interrupts.
// Optional input debouncer enabled by defining GPIO_DEBOUNCE_EN.
module gpio_bank_ctrl #(
   parameter int unsigned WIDTH       = 36,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_TICK     = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reg_wr,
   input  logic             reg_rd,
   input  logic [2:0]       reg_addr,
   input  logic [WIDTH-1:0] reg_wdata,
   output logic [WIDTH-1:0] reg_rdata,
   output logic             reg_rvalid,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   typedef enum logic [2:0] {
      A_DIR     = 3'd0,
      A_OUT     = 3'd1,
      A_IN      = 3'd2,
      A_RISE_EN = 3'd3,
      A_FALL_EN = 3'd4,
      A_MASK    = 3'd5,
      A_STATUS  = 3'd6,
      A_NONE    = 3'd7
   } reg_sel_e;

   localparam int unsigned GW = $clog2(SYNC_STAGES + 2);

   if (WIDTH < 1 || WIDTH > 64 || SYNC_STAGES < 2 || DB_TICK < 1) begin : g_bad_cfg
      $error("gpio_bank_ctrl: unsupported parameter set");
   end

   reg_sel_e         sel;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] pin_s, pin_q, pin_p;
   logic [WIDTH-1:0] dir_r, out_r, rise_en, fall_en, mask, status;
   logic [WIDTH-1:0] edge_set, w1c, rd_mux;
   logic [GW-1:0]    guard_cnt;
   logic             guard_done, db_warm, armed;

   assign sel = reg_sel_e'(reg_addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= gpio_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign pin_s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
   localparam int unsigned PW = (DB_TICK > 1) ? $clog2(DB_TICK) : 1;

   logic [PW-1:0]    pre_cnt;
   logic             db_tick;
   logic [2:0]       hist [WIDTH];
   logic [WIDTH-1:0] pin_db;
   logic [1:0]       tick_cnt;

   assign db_tick = (pre_cnt == PW'(DB_TICK - 1));

   // pin_q only moves once three consecutive tick samples agree
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt  <= '0;
         tick_cnt <= '0;
         db_warm  <= 1'b0;
         pin_db   <= '0;
         for (int unsigned i = 0; i < WIDTH; i++) hist[i] <= '0;
      end else begin
         pre_cnt <= db_tick ? '0 : pre_cnt + 1'b1;
         db_warm <= (tick_cnt == 2'd3);
         if (db_tick) begin
            if (tick_cnt != 2'd3) tick_cnt <= tick_cnt + 1'b1;
            for (int unsigned i = 0; i < WIDTH; i++) begin
               hist[i] <= {hist[i][1:0], pin_s[i]};
               if ({hist[i][1:0], pin_s[i]} == 3'b111)      pin_db[i] <= 1'b1;
               else if ({hist[i][1:0], pin_s[i]} == 3'b000) pin_db[i] <= 1'b0;
            end
         end
      end
   end

   assign pin_q = pin_db;
`else
   assign pin_q   = pin_s;
   assign db_warm = 1'b1;
`endif

   // Edge detection stays disarmed until the synchroniser (and debouncer) has
   // absorbed whatever level the pads held at reset release.
   assign guard_done = (guard_cnt == GW'(SYNC_STAGES + 1));
   assign armed      = guard_done & db_warm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         guard_cnt <= '0;
         pin_p     <= '0;
      end else begin
         if (!guard_done) guard_cnt <= guard_cnt + 1'b1;
         pin_p <= pin_q;
      end
   end

   assign edge_set = armed ? ((pin_q & ~pin_p & rise_en) | (~pin_q & pin_p & fall_en)) : '0;
   assign w1c      = (reg_wr && sel == A_STATUS) ? reg_wdata : '0;

   always_comb begin
      rd_mux = '0;
      case (sel)
         A_DIR:     rd_mux = dir_r;
         A_OUT:     rd_mux = out_r;
         A_IN:      rd_mux = pin_q;
         A_RISE_EN: rd_mux = rise_en;
         A_FALL_EN: rd_mux = fall_en;
         A_MASK:    rd_mux = mask;
         A_STATUS:  rd_mux = status;
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_r      <= '0;
         out_r      <= '0;
         rise_en    <= '0;
         fall_en    <= '0;
         mask       <= '0;
         status     <= '0;
         irq        <= 1'b0;
         reg_rdata  <= '0;
         reg_rvalid <= 1'b0;
      end else begin
         if (reg_wr) begin
            case (sel)
               A_DIR:     dir_r   <= reg_wdata;
               A_OUT:     out_r   <= reg_wdata;
               A_RISE_EN: rise_en <= reg_wdata;
               A_FALL_EN: fall_en <= reg_wdata;
               A_MASK:    mask    <= reg_wdata;
               default:   ;
            endcase
         end
         // a new edge wins over a simultaneous W1C of the same bit
         status     <= (status & ~w1c) | edge_set;
         irq        <= |(status & mask);
         reg_rvalid <= reg_rd;
         if (reg_rd) reg_rdata <= rd_mux;
      end
   end

   assign gpio_out = out_r;
   assign gpio_oe  = dir_r;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed self-checking bench for gpio_bank_ctrl (WIDTH=36, SYNC_STAGES=2, DB_TICK=8).
module tb_gpio_bank_ctrl;

   localparam int unsigned W = 36;

   logic         clk;
   logic         rst_n;
   logic         reg_wr, reg_rd;
   logic [2:0]   reg_addr;
   logic [W-1:0] reg_wdata, reg_rdata;
   logic         reg_rvalid;
   logic [W-1:0] gpio_in, gpio_out, gpio_oe;
   logic         irq;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   gpio_bank_ctrl #(.WIDTH(W), .SYNC_STAGES(2), .DB_TICK(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .reg_wr     (reg_wr),
      .reg_rd     (reg_rd),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_rdata  (reg_rdata),
      .reg_rvalid (reg_rvalid),
      .gpio_in    (gpio_in),
      .gpio_out   (gpio_out),
      .gpio_oe    (gpio_oe),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
      reg_addr  = a;
      reg_wdata = d;
      reg_wr    = 1'b1;
      tick();
      reg_wr    = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [2:0] a, input logic [63:0] exp);
      reg_addr = a;
      reg_rd   = 1'b1;
      tick();
      reg_rd   = 1'b0;
      check({tag, "_vld"}, 64'(reg_rvalid), 64'd1);
      check(tag, 64'(reg_rdata), exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      reg_wr    = 1'b0;
      reg_rd    = 1'b0;
      reg_addr  = '0;
      reg_wdata = '0;
      gpio_in   = '1;

      // T1: reset state, then no STATUS from pins already high
      ticks(3);
      check("rst_oe",     64'(gpio_oe),    64'd0);
      check("rst_out",    64'(gpio_out),   64'd0);
      check("rst_irq",    64'(irq),        64'd0);
      check("rst_rvalid", 64'(reg_rvalid), 64'd0);
      check("rst_rdata",  64'(reg_rdata),  64'd0);
      rst_n = 1'b1;
      ticks(40);
      rd("startup_status", 3'd6, 64'd0);
      rd("startup_in",     3'd2, 64'hF_FFFF_FFFF);
      check("startup_irq", 64'(irq), 64'd0);

      // reset landing on a pending read suppresses reg_rvalid
      reg_addr = 3'd2;
      reg_rd   = 1'b1;
      #2 rst_n = 1'b0;
      tick();
      reg_rd = 1'b0;
      check("midrst_rvalid", 64'(reg_rvalid), 64'd0);
      rst_n = 1'b1;
      tick();
      check("midrst_rvalid2", 64'(reg_rvalid), 64'd0);
      ticks(40);
      rd("midrst_status", 3'd6, 64'd0);

`ifndef GPIO_DEBOUNCE_EN
      gpio_in = '0;
      ticks(10);

      // T2: direction / output registers
      wr(3'd0, 36'h0F);
      check("dir_oe", 64'(gpio_oe), 64'h0F);
      wr(3'd1, 36'hA5);
      check("out_pad", 64'(gpio_out), 64'hA5);
      rd("rd_out", 3'd1, 64'hA5);
      tick();
      check("rvalid_once", 64'(reg_rvalid), 64'd0);
      check("rdata_hold",  64'(reg_rdata),  64'hA5);
      rd("rd_dir", 3'd0, 64'h0F);
      wr(3'd2, 36'hFF);
      wr(3'd7, 36'hFF);
      rd("in_ro",    3'd2, 64'd0);
      rd("addr7",    3'd7, 64'd0);
      rd("dir_kept", 3'd0, 64'h0F);
      check("out_kept", 64'(gpio_out), 64'hA5);

      // T3: rise interrupt latency and W1C
      wr(3'd3, 36'h1);
      wr(3'd5, 36'h1);
      gpio_in[0] = 1'b1;
      ticks(3);
      check("rise_irq_early", 64'(irq), 64'd0);
      tick();
      check("rise_irq", 64'(irq), 64'd1);
      rd("rise_status", 3'd6, 64'h1);
      wr(3'd6, 36'h1);
      check("w1c_irq_hold", 64'(irq), 64'd1);
      tick();
      check("w1c_irq_clr", 64'(irq), 64'd0);
      rd("w1c_status", 3'd6, 64'd0);

      // T4: masked fall, then unmask
      wr(3'd4, 36'h2);
      wr(3'd5, 36'h0);
      gpio_in[1] = 1'b1;
      ticks(5);
      gpio_in[1] = 1'b0;
      ticks(5);
      check("fall_masked_irq", 64'(irq), 64'd0);
      rd("fall_status", 3'd6, 64'h2);
      wr(3'd5, 36'h2);
      check("unmask_irq_wait", 64'(irq), 64'd0);
      tick();
      check("unmask_irq", 64'(irq), 64'd1);
      wr(3'd6, 36'h2);
      tick();
      check("fall_clr_irq", 64'(irq), 64'd0);

      // T5: W1C colliding with a new rise on the same bit
      wr(3'd5, 36'h1);
      gpio_in[0] = 1'b0;
      ticks(5);
      gpio_in[0] = 1'b1;
      ticks(4);
      check("coll_pre_irq", 64'(irq), 64'd1);
      gpio_in[0] = 1'b0;
      ticks(5);
      gpio_in[0] = 1'b1;
      ticks(2);
      wr(3'd6, 36'h1);
      check("coll_irq", 64'(irq), 64'd1);
      tick();
      check("coll_irq_stay", 64'(irq), 64'd1);
      rd("coll_status", 3'd6, 64'h1);

      // same-cycle read and write of OUT returns the old value
      wr(3'd1, 36'h3);
      reg_addr  = 3'd1;
      reg_wdata = 36'h5;
      reg_wr    = 1'b1;
      reg_rd    = 1'b1;
      tick();
      reg_wr = 1'b0;
      reg_rd = 1'b0;
      check("rdwr_vld",   64'(reg_rvalid), 64'd1);
      check("rdwr_rdata", 64'(reg_rdata),  64'h3);
      check("rdwr_pad",   64'(gpio_out),   64'h5);
      rd("rdwr_after", 3'd1, 64'h5);
      rd("in_readback", 3'd2, 64'h1);

      // top pin of the bank
      wr(3'd0, 36'h8_0000_0000);
      check("top_oe", 64'(gpio_oe), 64'h8_0000_0000);
`else
      // T6: debounce rejects a short pulse, accepts a held level
      gpio_in = '0;
      ticks(40);
      wr(3'd3, 36'h4);
      rd("db_base_status", 3'd6, 64'd0);
      gpio_in[2] = 1'b1;
      ticks(10);
      gpio_in[2] = 1'b0;
      ticks(40);
      rd("db_glitch_in",     3'd2, 64'd0);
      rd("db_glitch_status", 3'd6, 64'd0);
      gpio_in[2] = 1'b1;
      ticks(26);
      rd("db_level_in", 3'd2, 64'h4);
      ticks(13);
      rd("db_level_status", 3'd6, 64'h4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
